// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: size encodings,
// FSM states and the byte-enable helper.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Lane mask for a store of the given size at the given byte lane.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            SZ_B, SZ_BU: return 4'b0001 << lane;
            SZ_H, SZ_HU: return lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: store replication and enables, load
// extraction with sign/zero extension, and alignment/size legality.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wbe,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        bad
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        wbe   = byte_enable(size, lane);
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        wword = wdata;
        rdata = rword;
        bad   = 1'b0;
        case (size)
            SZ_B: begin
                wword = {4{wdata[7:0]}};
                rdata = {{24{rbyte[7]}}, rbyte};
            end
            SZ_BU: begin
                wword = {4{wdata[7:0]}};
                rdata = {24'd0, rbyte};
                bad   = write;
            end
            SZ_H: begin
                wword = {2{wdata[15:0]}};
                rdata = {{16{rhalf[15]}}, rhalf};
                bad   = lane[0];
            end
            SZ_HU: begin
                wword = {2{wdata[15:0]}};
                rdata = {16'd0, rhalf};
                bad   = lane[0] | write;
            end
            SZ_W:    bad = |lane;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Single-port byte-addressable data memory with a request/response handshake,
// optional wait states and RISC-V style load/store sizes.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     wait_cnt;
    logic           accept;

    logic           cur_write;
    logic [31:0]    cur_addr;
    logic [2:0]     cur_size;
    logic [31:0]    cur_wdata;

    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;
    logic [31:0]    load_data;
    logic [31:0]    rd_word;
    logic           align_bad;
    logic           range_bad;
    logic           err;
    logic           mem_we;
    logic [31:0]    resp_data;
    logic [31:0]    rdata_hold;
    logic           err_hold;

    logic [3:0][7:0] mem [DEPTH];
    logic [AW-1:0]  idx;

    assign accept    = req_valid && req_ready;
    assign idx       = cur_addr[AW+1:2];
    assign range_bad = (cur_addr[31:2] >= 30'(DEPTH));
    assign err       = align_bad | range_bad;
    assign resp_data = (err || cur_write) ? 32'd0 : load_data;

    dmem_align u_align (
        .size  (cur_size),
        .lane  (cur_addr[1:0]),
        .write (cur_write),
        .wdata (cur_wdata),
        .rword (rd_word),
        .wbe   (lane_be),
        .wword (lane_wdata),
        .rdata (load_data),
        .bad   (align_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        mem_we    = (state == ST_ACCESS) && cur_write && !err;
        rsp_rdata = (state == ST_RESP) ? resp_data : rdata_hold;
        rsp_err   = (state == ST_RESP) ? err : err_hold;
    end

    // Wait counter is loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 wait_cnt <= 4'd0;
        else if (accept)                            wait_cnt <= WAIT_LOAD;
        else if (state == ST_WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cur_write <= req_write;
            cur_addr  <= req_addr;
            cur_size  <= req_size;
            cur_wdata <= req_wdata;
        end
    end

    // Byte-enabled write and synchronous read share the ACCESS edge; the read
    // word is consumed during RESP.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we && lane_be[i]) mem[idx][i] <= lane_wdata[8*i +: 8];
            end
            rd_word <= mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_hold <= 32'd0;
            err_hold   <= 1'b0;
        end else if (state == ST_RESP) begin
            rdata_hold <= resp_data;
            err_hold   <= err;
        end
    end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words stored; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 0, extra access wait states inserted per request; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  3  RISC-V funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-010 req_wdata  input  32  store data, right-aligned (bits [7:0] for byte stores, [15:0] for halfword stores).
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  load result, already aligned and extended.
REQ-013 rsp_err  output  1  request rejected; valid only with rsp_valid.

Function
REQ-014 The block SHALL accept a request in any cycle where req_valid and req_ready are both high, and SHALL register req_write, req_addr, req_size and req_wdata at that edge.
REQ-015 The FSM SHALL have four states:
- IDLE: req_ready = 1.
- WAIT: counts down WAIT_CYCLES.
- ACCESS: performs the array write and registers read data.
- RESP: rsp_valid = 1.
REQ-016 FSM transitions SHALL be:
- IDLE->WAIT on acceptance when WAIT_CYCLES > 0.
- IDLE->ACCESS on acceptance when WAIT_CYCLES = 0.
- WAIT->ACCESS when the counter reaches 0.
- ACCESS->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-017 For a request accepted at the end of cycle T, rsp_valid SHALL be high in exactly cycle T+2+WAIT_CYCLES; req_ready SHALL be low in every state except IDLE.
REQ-018 There is no response backpressure; rsp_valid SHALL be a single-cycle pulse.
REQ-019 Word index is req_addr[31:2]; byte lane is req_addr[1:0].
REQ-020 An error SHALL be flagged when any of the following holds:
- word index >= DEPTH;
- H/HU with addr[0] = 1;
- W with addr[1:0] != 0;
- req_size is 3, 6 or 7;
- req_write = 1 with size 4 or 5.
REQ-021 On an error: no array write SHALL occur, rsp_err = 1, rsp_rdata = 0, and latency SHALL be unchanged.
REQ-022 Stores SHALL write only the addressed byte lanes:
- SB: one lane, data from wdata[7:0].
- SH: lanes {1,0} or {3,2}, data from wdata[15:0].
- SW: all four lanes.
Unaddressed lanes SHALL keep their contents.
REQ-023 A store response SHALL have rsp_rdata = 0 and rsp_err = 0.
REQ-024 Loads SHALL extract the addressed byte or halfword into bits [7:0] or [15:0]:
- B and H sign-extend.
- BU and HU zero-extend.
- W returns the full word.
REQ-025 A load issued after a store to the same address SHALL return the stored data, since the write completes in ACCESS before any later request is accepted.
REQ-026 rsp_rdata and rsp_err SHALL hold their values outside RESP until the next RESP; the bench SHALL only check them while rsp_valid = 1.
REQ-027 Inputs SHALL be ignored while req_ready = 0.

Reset
REQ-028 While rst_n = 0, the block SHALL hold: state = IDLE, wait counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 Reset asserted in WAIT or ACCESS SHALL abort the request: no response, and no write unless the ACCESS clock edge preceded reset assertion.
REQ-030 Memory contents SHALL NOT be reset or initialised.

Structure
REQ-031 Package dmem_pkg SHALL hold:
- the size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
- the FSM state enum;
- a function returning the 4-bit byte-enable from size and lane.
REQ-032 One combinational sub-module, dmem_align, SHALL perform:
- store lane replication and byte-enable generation;
- load lane extraction and sign/zero extension;
- misalignment and illegal-size detection.
REQ-033 The array SHALL be DEPTH x 4 bytes with per-byte write enables, inferable as block RAM with a synchronous read.

Verification
REQ-034 WAIT_CYCLES = 0: SW 0xDEADBEEF to 0x10, then LW from 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_valid two cycles after each acceptance, rsp_err = 0.
REQ-035 After REQ-034: SB 0x80 to 0x11 then LB from 0x11 -> 0xFFFFFF80; LBU from 0x11 -> 0x00000080; LW from 0x10 -> 0xDEAD80EF.
REQ-036 SH 0x8001 to 0x12 then LH from 0x12 -> 0xFFFF8001; LHU from 0x12 -> 0x00008001; LW from 0x10 -> 0x800180EF.
REQ-037 Each of these requests -> rsp_err = 1, rsp_rdata = 0, and a following LW from 0x10 unchanged:
- LW at 0x13;
- SH at 0x11;
- req_size = 3;
- SW at word index DEPTH.
REQ-038 WAIT_CYCLES = 3: back-to-back req_valid held high -> req_ready low for 5 cycles after each acceptance, rsp_valid at T+5, one request per 6 cycles.
REQ-039 WAIT_CYCLES = 3, reset pulsed during WAIT of an SW to 0x20 -> no rsp_valid, req_ready = 1, and a subsequent LW from 0x20 returns the prior contents.
